// File: rtl/y86_pkg.sv
// Y86-64 multi-cycle controller: shared constants, state encoding
// and instruction-class helpers.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_PC,
    S_HALT
  } state_t;

  function automatic logic usesMem(input logic [3:0] ic);
    return ic inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction

  function automatic logic memWrite(input logic [3:0] ic);
    return ic inside {IRMMOVQ, ICALL, IPUSHQ};
  endfunction

  function automatic logic writesE(input logic [3:0] ic,
                                   input logic c);
    return (ic inside {IIRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ})
        || (ic == IRRMOVQ && c);
  endfunction

  function automatic logic writesM(input logic [3:0] ic);
    return ic inside {IMRMOVQ, IPOPQ};
  endfunction

endpackage

// File: rtl/y86_multicycle_ctrl_if.sv
// Shared req/ack memory port between the sequencer (master)
// and the instruction/data memory (slave).
interface y86_multicycle_ctrl_if;
  logic fetch_req;
  logic mem_req;
  logic mem_we;
  logic mem_ack;
  logic mem_err;

  modport master (
    output fetch_req, mem_req, mem_we,
    input  mem_ack, mem_err
  );

  modport slave (
    input  fetch_req, mem_req, mem_we,
    output mem_ack, mem_err
  );
endinterface

// File: rtl/y86_wait_timer.sv
// Counts request cycles without ack; expired flags the cycle
// that is the TIMEOUT_CYC-th unanswered request cycle.
module y86_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign expired = inc && (cnt == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/y86_multicycle_ctrl.sv
// Y86-64 multi-cycle sequencer FETCH/DECODE/EXEC/MEM/WB/PC.
// Define Y86_PERF_CNT_EN to add cycle/retired counters.
module y86_multicycle_ctrl
  import y86_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
`ifdef Y86_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  y86_multicycle_ctrl_if.master bus,
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic       inst_valid,
  output logic       ir_we,
  output logic       cc_we,
  output logic       rf_we_e,
  output logic       rf_we_m,
  output logic       pc_we,
  output logic [2:0] stat,
  output logic       halted
`ifdef Y86_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] retired_cnt
`endif
);

  state_t state;
  logic   reqCyc;
  logic   expired;

  assign reqCyc = (state == S_FETCH) || (state == S_MEM);

  y86_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!reqCyc || bus.mem_ack),
    .inc    (reqCyc && !bus.mem_ack),
    .expired(expired)
  );

  assign bus.fetch_req = (state == S_FETCH);
  assign bus.mem_req   = (state == S_MEM);
  assign bus.mem_we    = (state == S_MEM) && memWrite(icode);
  assign ir_we   = (state == S_FETCH) && bus.mem_ack;
  assign cc_we   = (state == S_EXEC) && (icode == IOPQ);
  assign rf_we_e = (state == S_WB) && writesE(icode, cnd);
  assign rf_we_m = (state == S_WB) && writesM(icode);
  assign pc_we   = (state == S_PC);
  assign halted  = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      stat  <= STAT_AOK;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ack) begin
            if (bus.mem_err) begin
              stat  <= STAT_ADR;
              state <= S_HALT;
            end else if (!inst_valid) begin
              stat  <= STAT_INS;
              state <= S_HALT;
            end else begin
              state <= S_DECODE;
            end
          end else if (expired) begin
            stat  <= STAT_ADR;
            state <= S_HALT;
          end
        end
        S_DECODE: begin
          if (icode == IHALT) begin
            stat  <= STAT_HLT;
            state <= S_HALT;
          end else if (icode > IPOPQ) begin
            stat  <= STAT_INS;
            state <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: state <= usesMem(icode) ? S_MEM : S_WB;
        S_MEM: begin
          if (bus.mem_ack) begin
            if (bus.mem_err) begin
              stat  <= STAT_ADR;
              state <= S_HALT;
            end else begin
              state <= S_WB;
            end
          end else if (expired) begin
            stat  <= STAT_ADR;
            state <= S_HALT;
          end
        end
        S_WB:    state <= S_PC;
        S_PC:    state <= S_FETCH;
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef Y86_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_we) retired_cnt <= retired_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_multicycle_ctrl.sv
// Randomized bench for y86_multicycle_ctrl: a per-instruction
// cycle script built from the ISA rules, checked every cycle.
module tb_y86_multicycle_ctrl;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] icode = 4'h1;
  logic       cnd = 1'b0;
  logic       inst_valid = 1'b1;
  logic       ir_we, cc_we, rf_we_e, rf_we_m, pc_we, halted;
  logic [2:0] stat;
`ifdef Y86_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
  int unsigned expCyc = 0;
  int unsigned expRet = 0;
`endif

  int vectors = 0;
  int fails = 0;

  y86_multicycle_ctrl_if bus ();

  y86_multicycle_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .icode     (icode),
    .cnd       (cnd),
    .inst_valid(inst_valid),
    .ir_we     (ir_we),
    .cc_we     (cc_we),
    .rf_we_e   (rf_we_e),
    .rf_we_m   (rf_we_m),
    .pc_we     (pc_we),
    .stat      (stat),
    .halted    (halted)
`ifdef Y86_PERF_CNT_EN
    , .cycle_cnt  (cycle_cnt)
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ack, err;
    logic fr, mr, mw, ir, cc, re, rm, pc, h;
    logic [2:0] st;
  } cyc_t;

  cyc_t q[$];
  logic [2:0] haltStat;

  function automatic cyc_t idle();
    cyc_t c;
    c = '{default: '0};
    c.st  = 3'd1;
    c.ack = ($urandom_range(0, 3) == 0);
    c.err = 1'($urandom);
    return c;
  endfunction

  // One request phase: ack lands on req cycle wt+1 unless the
  // TO-th cycle passes first; returns 1 when the phase faults.
  function automatic bit reqPhase(bit isData, bit we, int wt, bit err);
    for (int k = 1; k <= TO; k++) begin
      cyc_t c = idle();
      c.ack = 1'b0;
      c.err = 1'b0;
      if (isData) begin
        c.mr = 1'b1;
        c.mw = we;
      end else begin
        c.fr = 1'b1;
      end
      if (k == wt + 1) begin
        c.ack = 1'b1;
        c.err = err;
        c.ir  = !isData;
        q.push_back(c);
        return err;
      end
      q.push_back(c);
    end
    return 1'b1;
  endfunction

  function automatic void build(logic [3:0] ic, bit cn, bit vld,
                                int fw, bit fe, int mw, bit me);
    cyc_t c;
    int iv = int'(ic);
    bit isData = (iv == 4 || iv == 5 || iv == 8
               || iv == 9 || iv == 10 || iv == 11);
    bit isWr = (iv == 4 || iv == 8 || iv == 10);
    q.delete();
    haltStat = 3'd0;
    if (reqPhase(1'b0, 1'b0, fw, fe)) haltStat = 3'd3;
    else if (!vld) haltStat = 3'd4;
    if (haltStat == 0) begin
      q.push_back(idle());
      if (iv == 0) haltStat = 3'd2;
      else if (iv > 11) haltStat = 3'd4;
    end
    if (haltStat == 0) begin
      c = idle();
      c.cc = (iv == 6);
      q.push_back(c);
      if (isData && reqPhase(1'b1, isWr, mw, me)) haltStat = 3'd3;
    end
    if (haltStat == 0) begin
      c = idle();
      c.re = (iv == 3 || iv == 6 || iv >= 8) || (iv == 2 && cn);
      c.rm = (iv == 5 || iv == 11);
      q.push_back(c);
      c = idle();
      c.pc = 1'b1;
      q.push_back(c);
    end else begin
      for (int k = 0; k < 3; k++) begin
        c = idle();
        c.h  = 1'b1;
        c.st = haltStat;
        q.push_back(c);
      end
    end
  endfunction

  task automatic check(cyc_t c, int idx);
    logic [11:0] obs, exp;
    obs = {bus.fetch_req, bus.mem_req, bus.mem_we, ir_we, cc_we,
           rf_we_e, rf_we_m, pc_we, halted, stat};
    exp = {c.fr, c.mr, c.mw, c.ir, c.cc, c.re, c.rm, c.pc, c.h, c.st};
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL cyc%0d icode=%h observed=%b expected=%b",
             idx, icode, obs, exp);
    end
`ifdef Y86_PERF_CNT_EN
    vectors++;
    assert (cycle_cnt === expCyc && retired_cnt === expRet) else begin
      fails++;
      $error("FAIL perf cyc%0d observed=%0d/%0d expected=%0d/%0d",
             idx, cycle_cnt, retired_cnt, expCyc, expRet);
    end
    if (!c.h) expCyc++;
    if (c.pc) expRet++;
`endif
  endtask

  task automatic runInstr(logic [3:0] ic, bit cn, bit vld, int fw,
                          bit fe, int mw, bit me, int rstAt);
    bit didRst = 1'b0;
    build(ic, cn, vld, fw, fe, mw, me);
    icode = ic;
    cnd = cn;
    inst_valid = vld;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst = (i == rstAt);
      bus.mem_ack = q[i].ack;
      bus.mem_err = q[i].err;
      #1;
      if (rst) begin
        didRst = 1'b1;
        break;
      end
      check(q[i], i);
    end
    if (haltStat != 0 && !didRst) begin
      @(negedge clk);
      rst = 1'b1;
      bus.mem_ack = 1'b0;
      didRst = 1'b1;
    end
`ifdef Y86_PERF_CNT_EN
    if (didRst) begin
      expCyc = 0;
      expRet = 0;
    end
`endif
  endtask

  function automatic int pickWait();
    if ($urandom_range(0, 9) < 7) return $urandom_range(0, 3);
    return $urandom_range(TO - 3, TO + 2);
  endfunction

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;
    repeat (2) @(negedge clk);
    // directed: irmovq, mrmovq w/ 3 waits, cmov both ways
    runInstr(4'h3, 0, 1, 0, 0, 0, 0, -1);
    runInstr(4'h5, 0, 1, 0, 0, 3, 0, -1);
    runInstr(4'h2, 0, 1, 0, 0, 0, 0, -1);
    runInstr(4'h2, 1, 1, 1, 0, 0, 0, -1);
    // fetch timeout, then ack landing on the last allowed cycle
    runInstr(4'h1, 0, 1, TO + 4, 0, 0, 0, -1);
    runInstr(4'h1, 0, 1, TO - 1, 0, 0, 0, -1);
    runInstr(4'hA, 0, 1, 0, 0, TO - 1, 0, -1);
    runInstr(4'h9, 0, 1, 0, 0, TO, 0, -1);
    // halt, illegal icode, invalid bytes, fetch/data addr errors
    runInstr(4'h0, 0, 1, 0, 0, 0, 0, -1);
    runInstr(4'hC, 0, 1, 0, 0, 0, 0, -1);
    runInstr(4'h6, 0, 0, 2, 0, 0, 0, -1);
    runInstr(4'h6, 0, 1, 1, 1, 0, 0, -1);
    runInstr(4'h8, 0, 1, 0, 0, 2, 1, -1);
    // reset in the middle of a pushq data access
    runInstr(4'hA, 0, 1, 0, 0, 5, 0, 5);
    runInstr(4'h7, 0, 1, 0, 0, 0, 0, -1);
    for (int n = 0; n < 300; n++) begin
      logic [3:0] ic;
      ic = ($urandom_range(0, 19) == 0) ? 4'h0 : 4'($urandom);
      runInstr(ic, 1'($urandom), $urandom_range(0, 19) != 0,
               pickWait(), $urandom_range(0, 24) == 0,
               pickWait(), $urandom_range(0, 24) == 0,
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20)
                                           : -1);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
